mult_div_unit: RTL
==================

// Module: mult_div_unit
// PURPOSE
//  Iterative radix-2 multiply/divide unit for MULT/MULTU/DIV/DIVU. Sits directly upstream of the
//  register file's HI/LO write port. Takes rs/rt operands from the register read ports.
//  On completion it presents a 64-bit {hi,lo} result and a one-cycle write strobe.
//  Those drive write_data64, writeRegs and hilo.
// PARAMETERS
//  WIDTH   32   operand width; result is 2*WIDTH; iteration count = WIDTH
// PORTS
//  clock    in   1        single clock, all state updates on posedge
//  reset    in   1        synchronous, active-high
//  start    in   1        request; sampled only when busy==0
//  op       in   2        00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
//  rs       in   WIDTH    multiplicand / dividend
//  rt       in   WIDTH    multiplier / divisor
//  busy     out  1        operation in progress
//  done     out  1        one-cycle pulse: result valid; drive writeRegs and hilo
//  result   out  2*WIDTH  [2W-1:W]=hi, [W-1:0]=lo (matches register-file 64-bit layout)
//  div0     out  1        valid with done: last DIV/DIVU had rt==0
// BEHAVIOUR
//  - Reset (sync, active-high): state=IDLE, busy=0, done=0, result=0, div0=0, counter=0.
//  - Reset mid-operation aborts: no done pulse; busy=0 after the reset edge.
//  - States: IDLE -> RUN -> FIN -> IDLE.
//  - IDLE: on edge with start=1, latch op, magnitudes |rs|,|rt| (signed ops) or raw values (unsigned ops).
//    Also latch the sign flags. Then cnt=0, busy<=1, state<=RUN.
//  - RUN: one iteration per edge.
//    - mult: shift-add into 2W accumulator.
//    - div: restoring shift-subtract; quotient in low half, partial remainder in high half.
//    - cnt increments each edge; on the edge where cnt==WIDTH-1, state<=FIN.
//  - FIN: one edge; apply sign fix, register result, done<=1, busy<=0, state<=IDLE.
//  - Latency: done is high in the cycle after the (WIDTH+2)-th edge counting the start-sampling edge as edge 1.
//    That is 34 cycles for WIDTH=32. Fixed for all ops including rt==0.
//  - done is high exactly 1 cycle. result and div0 hold until the next FIN edge or reset.
//  - start while busy=1 is ignored (not queued). Operands may change freely after the sampling edge.
//  - start in the cycle done is high is accepted (back-to-back, no bubble).
//  - Sign rules: MULT product negated iff sign(rs)!=sign(rt).
//    DIV quotient negated iff signs differ; remainder takes the sign of rs.
//  - Arithmetic is modulo 2^WIDTH per half.
//  - rs=-2^(W-1), rt=-1 (DIV): lo=0x80000000, hi=0, no flag.
//  - Divide by zero: lo=all ones, hi=rs (original, un-negated). div0=1 with done.
//    div0=0 for every other completion.
//  - MULT/MULTU: hi=upper product, lo=lower product.
//  - DIV/DIVU: lo=quotient, hi=remainder.
// STRUCTURE
//  - Shared package md_pkg: op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU) and state enum
//    (MD_IDLE, MD_RUN, MD_FIN).
//  - The HI/LO field split also belongs in md_pkg; other units decode it.
//  - One natural sub-module: md_sign_fix, combinational. Inputs: raw 2W result, op, sign flags, div0.
//    Output: final {hi,lo}. Used in FIN.
//  - Counter width $clog2(WIDTH). Datapath registers: acc[2W], divisor/multiplicand[W], flags.
// TESTING
//  1. MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> result=0xFFFFFFFE_00000001, done 34 cycles after start, busy low with done.
//  2. MULT rs=-3 rt=5 -> result=0xFFFFFFFF_FFFFFFF1; MULT rs=-4 rt=-4 -> 0x00000000_00000010.
//  3. DIV rs=-7 rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//     DIVU rs=7 rt=2 -> lo=3, hi=1.
//     DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
//  4. DIVU rs=7 rt=0 -> lo=0xFFFFFFFF, hi=7, div0=1, same 34-cycle latency; following MULTU clears div0.
//  5. start pulsed at cycles 5 and 20 of a running op -> ignored; exactly one done.
//     Start in done cycle -> second done exactly 34 cycles later.
//  6. reset asserted at RUN cycle 10 -> busy=0, done never pulses, result=0.
//     New start after reset completes normally.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit and its HI/LO consumers.
package md_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIN  = 2'd2
  } md_state_e;

  // Register-file 64-bit HI/LO layout: hi in the upper word, lo in the lower word.
  localparam int MD_XLEN = 32;
  typedef struct packed {
    logic [MD_XLEN-1:0] hi;
    logic [MD_XLEN-1:0] lo;
  } md_hilo_t;

  function automatic logic md_is_div(input md_op_e op);
    return op[1];
  endfunction

  function automatic logic md_is_signed(input md_op_e op);
    return !op[0];
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the issue stage and the multiply/divide unit.
interface mult_div_unit_if
  import md_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic               start;
  md_op_e             op;
  logic [WIDTH-1:0]   rs;
  logic [WIDTH-1:0]   rt;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] result;
  logic               div0;

  modport master (output start, op, rs, rt, input busy, done, result, div0);
  modport slave  (input start, op, rs, rt, output busy, done, result, div0);
endinterface

// File: rtl/mult_div_unit_sign_fix.sv
// Applies operand signs to the raw magnitude result and the divide-by-zero override.
module md_sign_fix
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] raw,
  input  md_op_e             op,
  input  logic               neg_a,
  input  logic               neg_b,
  input  logic               dz,
  output logic [2*WIDTH-1:0] fixed
);
  logic [WIDTH-1:0] q, r;

  always_comb begin
    q     = raw[WIDTH-1:0];
    r     = raw[2*WIDTH-1:WIDTH];
    fixed = raw;
    if (!md_is_div(op)) begin
      if (neg_a ^ neg_b) fixed = -raw;
    end else begin
      if (neg_a ^ neg_b) q = -q;
      // With a zero divisor the remainder register ends up holding |rs|, so the
      // rs-sign fix alone restores the original rs; only the quotient needs forcing.
      if (neg_a) r = -r;
      if (dz) q = '1;
      fixed = {r, q};
    end
  end
endmodule

// File: rtl/mult_div_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit; fixed WIDTH+2 cycle latency, one-cycle done strobe.
module mult_div_unit
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic            clock,
  input  logic            reset,
  mult_div_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  md_state_e          state;
  md_op_e             op_q;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, acc_nxt, fixed;
  logic [WIDTH-1:0]   dsr;
  logic               neg_a, neg_b, dz;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               sgn_a, sgn_b;
  logic [WIDTH:0]     mul_sum, div_rem, div_diff;

  always_comb begin
    sgn_a = md_is_signed(bus.op) && bus.rs[WIDTH-1];
    sgn_b = md_is_signed(bus.op) && bus.rt[WIDTH-1];
    mag_a = sgn_a ? -bus.rs : bus.rs;
    mag_b = sgn_b ? -bus.rt : bus.rt;
  end

  // One iteration: shift-add for multiply, restoring shift-subtract for divide.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, dsr} : '0);
    div_rem  = acc[2*WIDTH-1:WIDTH-1];
    div_diff = div_rem - {1'b0, dsr};
    if (md_is_div(op_q)) begin
      if (!div_diff[WIDTH]) acc_nxt = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else                  acc_nxt = {div_rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_nxt = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  md_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .raw   (acc),
    .op    (op_q),
    .neg_a (neg_a),
    .neg_b (neg_b),
    .dz    (dz),
    .fixed (fixed)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= MD_IDLE;
      op_q       <= MD_MULT;
      cnt        <= '0;
      acc        <= '0;
      dsr        <= '0;
      neg_a      <= 1'b0;
      neg_b      <= 1'b0;
      dz         <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.result <= '0;
      bus.div0   <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (bus.start) begin
            op_q     <= bus.op;
            neg_a    <= sgn_a;
            neg_b    <= sgn_b;
            dz       <= md_is_div(bus.op) && (bus.rt == '0);
            acc      <= {{WIDTH{1'b0}}, mag_a};
            dsr      <= mag_b;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= MD_RUN;
          end
        end
        MD_RUN: begin
          acc <= acc_nxt;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH-1)) state <= MD_FIN;
        end
        MD_FIN: begin
          bus.result <= fixed;
          bus.div0   <= dz;
          bus.done   <= 1'b1;
          bus.busy   <= 1'b0;
          state      <= MD_IDLE;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end
endmodule
